// File: rtl/ysyx_24100029_lsu.sv
// Memory-access stage: aligns store data, issues one data-memory transaction, extracts and extends load data.
// Latency: NONE/misaligned packets are valid for writeback 1 cycle after acceptance. Memory ops take 3 cycles with a zero-wait memory.
// Backpressure: one packet in flight. ex_ready is high only in IDLE, and the writeback packet is held in DONE until wb_ready.
module ysyx_24100029_lsu #(
    parameter int BW   = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [BW-1:0]   ex_alu_res,
    input  logic [BW-1:0]   ex_store_data,
    input  logic [3:0]      ex_mem_op,
    input  logic [RD_W-1:0] ex_rd,
    input  logic            ex_rd_wen,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [BW-1:0]   mem_addr,
    output logic            mem_wen,
    output logic [BW-1:0]   mem_wdata,
    output logic [3:0]      mem_wmask,
    input  logic            mem_rsp_valid,
    input  logic [BW-1:0]   mem_rdata,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [BW-1:0]   wb_data,
    output logic [RD_W-1:0] wb_rd,
    output logic            wb_rd_wen,
    output logic            wb_misalign
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [3:0] OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3, OP_LBU = 4'd4, OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB = 4'd9, OP_SH = 4'd10, OP_SW = 4'd11;

    state_t state, state_nxt;

    logic [BW-1:0]   addr_q, sd_q, wb_data_q;
    logic [3:0]      op_q;
    logic [RD_W-1:0] rd_q;
    logic            rd_wen_q, wb_rd_wen_q, wb_misalign_q;

    // Unknown op codes behave as NONE, so anything outside this list never touches memory.
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LBU) ||
               (op == OP_LHU) || (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
        return (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && a[0]) ||
               (((op == OP_LW) || (op == OP_SW)) && (a != 2'b00));
    endfunction

    logic accept, in_mem, in_mis, is_store;
    logic [BW-1:0] shifted, load_val;

    assign accept   = ex_valid && (state == IDLE);
    assign in_mem   = is_mem_op(ex_mem_op);
    assign in_mis   = in_mem && is_misaligned(ex_mem_op, ex_alu_res[1:0]);
    assign is_store = op_q[3];

    // State register; reset drops any packet in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: one request, one response, then hold until writeback accepts
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (in_mem && !in_mis) ? REQ : DONE;
            REQ:  if (mem_req_ready) state_nxt = WAIT;
            WAIT: if (mem_rsp_valid) state_nxt = DONE;
            DONE: if (wb_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ex_ready      = (state == IDLE);
    assign mem_req_valid = (state == REQ);
    assign wb_valid      = (state == DONE);

    // Request fields come from registered state only, so they stay stable while stalled in REQ
    always_comb begin
        mem_addr  = '0;
        mem_wen   = 1'b0;
        mem_wdata = '0;
        mem_wmask = 4'b0000;
        if (state == REQ) begin
            mem_addr = {addr_q[BW-1:2], 2'b00};
            mem_wen  = is_store;
            case (op_q)
                OP_SB: begin
                    mem_wdata = {4{sd_q[7:0]}};
                    mem_wmask = 4'b0001 << addr_q[1:0];
                end
                OP_SH: begin
                    mem_wdata = {2{sd_q[15:0]}};
                    mem_wmask = 4'b0011 << addr_q[1:0];
                end
                OP_SW: begin
                    mem_wdata = sd_q;
                    mem_wmask = 4'b1111;
                end
                default: ;
            endcase
        end
    end

    // Load alignment: bring the addressed byte/half down to bit 0, then extend
    always_comb begin
        shifted  = mem_rdata >> {addr_q[1:0], 3'b000};
        load_val = mem_rdata;
        case (op_q)
            OP_LB:   load_val = {{(BW-8){shifted[7]}}, shifted[7:0]};
            OP_LBU:  load_val = {{(BW-8){1'b0}}, shifted[7:0]};
            OP_LH:   load_val = {{(BW-16){shifted[15]}}, shifted[15:0]};
            OP_LHU:  load_val = {{(BW-16){1'b0}}, shifted[15:0]};
            default: load_val = mem_rdata;
        endcase
    end

    // Packet capture on acceptance and writeback result on memory response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q        <= '0;
            sd_q          <= '0;
            op_q          <= '0;
            rd_q          <= '0;
            rd_wen_q      <= 1'b0;
            wb_data_q     <= '0;
            wb_rd_wen_q   <= 1'b0;
            wb_misalign_q <= 1'b0;
        end else if (accept) begin
            addr_q        <= ex_alu_res;
            sd_q          <= ex_store_data;
            op_q          <= ex_mem_op;
            rd_q          <= ex_rd;
            rd_wen_q      <= ex_rd_wen;
            wb_data_q     <= ex_alu_res;
            // Memory ops decide their write enable at response time
            wb_rd_wen_q   <= !in_mem && ex_rd_wen && (ex_rd != '0);
            wb_misalign_q <= in_mis;
        end else if ((state == WAIT) && mem_rsp_valid) begin
            wb_data_q   <= is_store ? '0 : load_val;
            wb_rd_wen_q <= !is_store && rd_wen_q && (rd_q != '0);
        end
    end

    assign wb_data     = wb_data_q;
    assign wb_rd       = rd_q;
    assign wb_rd_wen   = wb_rd_wen_q;
    assign wb_misalign = wb_misalign_q;
endmodule

// File: tb/tb_ysyx_24100029_lsu.sv
// Bench for the LSU: directed scenarios followed by randomized packets, checked against a transaction-level model.
// Latency: inputs are driven and outputs sampled on the falling clock edge.
// Backpressure: random memory and writeback stalls are applied while the held outputs are checked for stability.
module tb_ysyx_24100029_lsu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_alu_res, ex_store_data;
    logic [3:0]  ex_mem_op;
    logic [4:0]  ex_rd;
    logic        ex_rd_wen;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wen;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic        wb_valid, wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_rd_wen, wb_misalign;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ysyx_24100029_lsu #(.BW(32), .RD_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_res(ex_alu_res),
        .ex_store_data(ex_store_data), .ex_mem_op(ex_mem_op), .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_rd_wen(wb_rd_wen), .wb_misalign(wb_misalign)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ex_alu_res = 0; ex_store_data = 0; ex_mem_op = 0; ex_rd = 0; ex_rd_wen = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0; wb_ready = 0;
    endtask

    // Runs one packet end to end. Precondition: just after a falling edge, DUT in IDLE.
    task automatic run_txn(input logic [31:0] alu, input logic [31:0] sd, input logic [3:0] op,
                           input logic [4:0] rd, input logic rwen, input logic [31:0] rdata,
                           input int req_dly, input int rsp_dly, input int wb_dly);
        int size;
        bit is_load, is_st, is_mem, mis;
        logic [31:0] e_wdata, e_data, sh;
        logic [3:0]  e_mask;
        logic        e_wen;
        // Reference model derived from the op semantics
        is_load = (op inside {1, 2, 3, 4, 5});
        is_st   = (op inside {9, 10, 11});
        is_mem  = is_load || is_st;
        size    = (op inside {2, 5, 10}) ? 2 : (op inside {3, 11}) ? 4 : 1;
        mis     = is_mem && ((alu % size) != 0);
        e_wdata = 0; e_mask = 0;
        if (op == 9)  begin e_wdata = {4{sd[7:0]}};  e_mask = 4'(1 << (alu % 4)); end
        if (op == 10) begin e_wdata = {2{sd[15:0]}}; e_mask = 4'(3 << (alu % 4)); end
        if (op == 11) begin e_wdata = sd;            e_mask = 4'hF; end
        sh = rdata >> (8 * (alu % 4));
        case (op)
            1: begin e_data = sh & 32'hFF;   if (e_data >= 32'h80)   e_data = e_data | 32'hFFFF_FF00; end
            2: begin e_data = sh & 32'hFFFF; if (e_data >= 32'h8000) e_data = e_data | 32'hFFFF_0000; end
            3: e_data = rdata;
            4: e_data = sh & 32'hFF;
            5: e_data = sh & 32'hFFFF;
            default: e_data = is_st ? 32'h0 : alu;
        endcase
        e_wen = rwen && (rd != 0) && !is_st && !mis;

        ex_valid = 1; ex_alu_res = alu; ex_store_data = sd; ex_mem_op = op; ex_rd = rd; ex_rd_wen = rwen;
        check("ex_ready_idle", 32'(ex_ready), 32'd1);
        @(negedge clk);
        ex_valid = 0; ex_alu_res = $urandom; ex_store_data = $urandom;
        if (is_mem && !mis) begin
            for (int k = 0; k <= req_dly; k++) begin
                check("req_valid", 32'(mem_req_valid), 32'd1);
                check("req_addr",  mem_addr, alu & 32'hFFFF_FFFC);
                check("req_wen",   32'(mem_wen), 32'(is_st));
                check("req_wdata", mem_wdata, e_wdata);
                check("req_wmask", 32'(mem_wmask), 32'(e_mask));
                mem_req_ready = (k == req_dly);
                @(negedge clk);
            end
            mem_req_ready = 0;
            for (int k = 0; k <= rsp_dly; k++) begin
                check("wait_no_req", 32'(mem_req_valid), 32'd0);
                check("wait_no_wb",  32'(wb_valid), 32'd0);
                mem_rsp_valid = (k == rsp_dly);
                mem_rdata     = (k == rsp_dly) ? rdata : $urandom;
                @(negedge clk);
            end
            mem_rsp_valid = 0; mem_rdata = $urandom;
        end else begin
            check("no_mem_req", 32'(mem_req_valid), 32'd0);
        end
        // DONE: held stable under backpressure; a competing packet must not be taken
        for (int k = 0; k <= wb_dly; k++) begin
            check("wb_valid",    32'(wb_valid), 32'd1);
            check("wb_data",     wb_data, mis ? wb_data : e_data);
            check("wb_rd",       32'(wb_rd), 32'(rd));
            check("wb_rd_wen",   32'(wb_rd_wen), 32'(e_wen));
            check("wb_misalign", 32'(wb_misalign), 32'(mis));
            check("ex_ready_done", 32'(ex_ready), 32'd0);
            ex_valid = 1; ex_mem_op = 0; ex_rd = 5'(k + 1); ex_rd_wen = 1;
            wb_ready = (k == wb_dly);
            @(negedge clk);
        end
        ex_valid = 0; wb_ready = 0;
        check("back_idle_ready", 32'(ex_ready), 32'd1);
        check("back_idle_wb",    32'(wb_valid), 32'd0);
    endtask

    initial begin
        int op, sz;
        logic [31:0] a;
        idle_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        check("rst_ex_ready", 32'(ex_ready), 32'd1);
        check("rst_req",      32'(mem_req_valid), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_data",  wb_data, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_wb_flags", {29'd0, wb_rd_wen, wb_misalign, mem_wen}, 32'd0);
        rst_n = 1;
        @(negedge clk);

        // Directed scenarios
        run_txn(32'h1234_5678, 32'h0, 4'd0, 5'd5, 1'b1, 32'h0, 0, 0, 0);
        run_txn(32'h8000_0003, 32'h0, 4'd1, 5'd7, 1'b1, 32'h80FF_0011, 3, 0, 0);
        run_txn(32'h8000_0003, 32'h0, 4'd4, 5'd7, 1'b1, 32'h80FF_0011, 3, 0, 0);
        run_txn(32'h0000_0102, 32'hABCD_1234, 4'd10, 5'd3, 1'b1, 32'h0, 0, 1, 0);
        run_txn(32'h0000_0102, 32'h0, 4'd3, 5'd9, 1'b1, 32'h0, 0, 0, 0);
        run_txn(32'h0000_0040, 32'h0, 4'd3, 5'd0, 1'b1, 32'hCAFE_F00D, 0, 0, 4);

        // Reset in the middle of WAIT
        ex_valid = 1; ex_alu_res = 32'h200; ex_mem_op = 4'd3; ex_rd = 5'd4; ex_rd_wen = 1;
        @(negedge clk);
        ex_valid = 0; mem_req_ready = 1;
        @(negedge clk);
        mem_req_ready = 0;
        check("pre_rst_in_wait", {30'd0, mem_req_valid, wb_valid}, 32'd0);
        #2 rst_n = 0;
        #1;
        check("mid_rst_ex_ready", 32'(ex_ready), 32'd1);
        check("mid_rst_req",      32'(mem_req_valid), 32'd0);
        check("mid_rst_wb",       32'(wb_valid), 32'd0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        run_txn(32'h0000_0104, 32'h0, 4'd5, 5'd6, 1'b1, 32'h9876_8001, 0, 0, 0);

        // Randomized packets
        for (int n = 0; n < 200; n++) begin
            op = $urandom_range(0, 15);
            a  = $urandom;
            sz = (op inside {2, 5, 10}) ? 2 : (op inside {3, 11}) ? 4 : 1;
            if ($urandom_range(0, 3) != 0) a = a - (a % sz);
            run_txn(a, $urandom, 4'(op), 5'($urandom_range(0, 31)), 1'($urandom),
                    $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ysyx_24100029_lsu.md
Name: ysyx_24100029_lsu

Overview:
Memory-access stage directly downstream of the execute-stage ALU. It consumes the ALU result (an effective address for loads/stores, or a writeback value for all other instructions) with a valid/ready handshake. It performs at most one request/response transaction on a simple 32-bit data-memory port, aligns and extends load data, and hands a writeback packet to the WB stage. It also flags misaligned accesses, which never reach memory.

Parameters:
BW, 32, datapath/address width; only 32 is supported (byte-lane logic is 4 lanes)
RD_W, 5, destination register index width

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
ex_valid  in  1  EX packet valid
ex_ready  out  1  LSU can accept a packet
ex_alu_res  in  BW  ALU result: effective address or writeback value
ex_store_data  in  BW  rs2 value for stores
ex_mem_op  in  4  0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 9 SB, 10 SH, 11 SW; any other code = NONE
ex_rd  in  RD_W  destination register
ex_rd_wen  in  1  instruction writes rd
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  BW  word-aligned address ({addr[BW-1:2],2'b00})
mem_wen  out  1  1 = store
mem_wdata  out  BW  lane-replicated store data
mem_wmask  out  4  byte-lane write enables (0 for loads)
mem_rsp_valid  in  1  response/ack valid (load data or store ack)
mem_rdata  in  BW  load data word
wb_valid  out  1  writeback packet valid
wb_ready  in  1  WB accepts packet
wb_data  out  BW  writeback value
wb_rd  out  RD_W  destination register
wb_rd_wen  out  1  effective rd write enable
wb_misalign  out  1  access was misaligned (load or store)

Behaviour:
- Reset (async assert, sync-free deassert): state=IDLE. All outputs are 0 except ex_ready=1. Registered packet is cleared. Reset mid-transaction drops the packet and returns to IDLE.
- FSM states IDLE, REQ, WAIT, DONE. ex_ready = (state==IDLE). mem_req_valid = (state==REQ). wb_valid = (state==DONE).
- IDLE: on ex_valid&&ex_ready, latch alu_res, store_data, mem_op, rd, rd_wen.
  - NONE -> DONE; wb_data=alu_res, wb_rd_wen=rd_wen.
  - Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) -> DONE; wb_misalign=1, wb_rd_wen=0, no memory request.
  - Otherwise -> REQ.
- REQ: mem_addr/mem_wen/mem_wdata/mem_wmask remain stable while mem_req_valid=1 and mem_req_ready=0. On mem_req_ready -> WAIT.
- WAIT: mem_rsp_valid is sampled only here; a response in the cycle of request acceptance is illegal from the memory side. On mem_rsp_valid -> DONE.
  - Load: register extracted data, wb_rd_wen=rd_wen.
  - Store: wb_rd_wen=0, wb_data=0.
- DONE: wb_* outputs are held stable until wb_ready. On wb_valid&&wb_ready -> IDLE. There is no new acceptance in that same cycle.
- Latency: NONE/misaligned packet: wb_valid the cycle after acceptance. Memory op with zero-wait memory (req_ready=1, rsp one cycle later): wb_valid 3 cycles after acceptance.
- Store data: SB wdata={4{sd[7:0]}}, wmask=4'b0001<<a[1:0]. SH wdata={2{sd[15:0]}}, wmask=4'b0011<<a[1:0]. SW wdata=sd, wmask=4'b1111.
- Load: shifted = mem_rdata >> (8*a[1:0]). LB/LBU take shifted[7:0]; LH/LHU take shifted[15:0]. Signed ops sign-extend, unsigned ops zero-extend; LW takes the word unchanged.
- wb_rd_wen is forced to 0 when rd==0.

Test Plan:
- Reset: assert rst_n=0 mid-WAIT -> ex_ready=1, mem_req_valid=0, wb_valid=0 asynchronously; after release, next packet proceeds normally.
- NONE: alu_res=0x1234_5678, rd=5, rd_wen=1 -> next cycle wb_valid=1, wb_data=0x12345678, wb_rd=5, wb_rd_wen=1; no mem_req_valid.
- LB at 0x8000_0003, mem_rdata=0x80FF_0011, req_ready held low 3 cycles -> mem_addr=0x8000_0000 stable throughout; wb_data=0xFFFF_FF80. Repeat as LBU -> 0x0000_0080.
- SH at 0x100 offset 2, sd=0xABCD_1234 -> mem_wdata=0x1234_1234, wmask=4'b1100, mem_wen=1; after ack, wb_valid=1, wb_rd_wen=0.
- LW at 0x0000_0102 -> no memory request, wb_misalign=1, wb_rd_wen=0 the next cycle.
- Backpressure: wb_ready=0 for 4 cycles in DONE -> wb_* stable, ex_ready=0, second ex_valid not accepted until the cycle after the wb handshake.
